// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeders: FSM state encoding and
// default geometry constants.
package systolic_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS  = 4;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register chain carrying one lane's data and valid; LEN=0 is a
// plain wire so lane 0 of the feeder sees no extra delay.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int LEN   = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  if (LEN == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rstn_i;
    assign data_o = data_i;
    assign vld_o  = vld_i;
  end else begin : g_chain
    logic [WIDTH-1:0] dat_p [LEN];
    logic [LEN-1:0]   vld_p;

    // Data is cleared on reset too so the west edge of the array goes quiet at once.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int i = 0; i < LEN; i++) dat_p[i] <= '0;
        vld_p <= '0;
      end else begin
        dat_p[0] <= data_i;
        vld_p[0] <= vld_i;
        for (int i = 1; i < LEN; i++) begin
          dat_p[i] <= dat_p[i-1];
          vld_p[i] <= vld_p[i-1];
        end
      end
    end

    assign data_o = dat_p[LEN-1];
    assign vld_o  = vld_p[LEN-1];
  end

endmodule

// File: rtl/systolic_west_feeder.sv
// Buffers a K-beat tile of row vectors, then streams it into PE column 0 with
// a one-cycle-per-row diagonal skew.
module systolic_west_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_ROWS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic [$clog2(DEPTH+1)-1:0]  k_len_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [ROWS*WIDTH-1:0]       in_data_i,
  output logic [ROWS*WIDTH-1:0]       west_o,
  output logic [ROWS-1:0]             west_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int KW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(DEPTH+ROWS+1);
  localparam int LW = ROWS*WIDTH;

  feeder_state_e  state_q, state_d;
  logic [KW-1:0]  k_q, k_clamp, wr_ptr_q;
  logic [TW-1:0]  t_q;
  logic [LW-1:0]  mem [DEPTH];
  logic           accept, last_beat, last_t, rd_en;
  logic [LW-1:0]  rd_data_p0;
  logic           rd_vld_p0;

  assign k_clamp   = (k_len_i > KW'(DEPTH)) ? KW'(DEPTH) : k_len_i;
  assign accept    = (state_q == ST_LOAD) && in_valid_i;
  assign last_beat = (wr_ptr_q == k_q - 1'b1);
  // t ends at K+ROWS-2; compare with +2 on both sides to stay non-negative for ROWS=1.
  assign last_t    = ((t_q + TW'(2)) == (TW'(k_q) + TW'(ROWS)));
  assign rd_en     = (state_q == ST_STREAM) && (t_q < TW'(k_q));

  assign in_ready_o = (state_q == ST_LOAD);
  assign busy_o     = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (k_len_i == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && last_beat) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_t) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      wr_ptr_q <= '0;
      t_q      <= '0;
      done_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_i) begin
        k_q      <= k_clamp;
        wr_ptr_q <= '0;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      t_q    <= (state_q == ST_STREAM) ? t_q + 1'b1 : '0;
      done_o <= (state_q == ST_DONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr_q[AW-1:0]] <= in_data_i;
  end

  // p0: one buffer row per STREAM cycle, shared by every lane
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_vld_p0  <= 1'b0;
      rd_data_p0 <= '0;
    end else begin
      rd_vld_p0  <= rd_en;
      rd_data_p0 <= rd_en ? mem[t_q[AW-1:0]] : '0;
    end
  end

  // p1..pROWS-1: per-lane skew, lane r delayed by r cycles
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .WIDTH(WIDTH),
      .LEN  (r)
    ) u_skew (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .data_i(rd_data_p0[r*WIDTH +: WIDTH]),
      .vld_i (rd_vld_p0),
      .data_o(west_o[r*WIDTH +: WIDTH]),
      .vld_o (west_valid_o[r])
    );
  end

endmodule

// File: tb/tb_systolic_west_feeder.sv
// Directed bench for systolic_west_feeder: load/stream/done sequencing, skew,
// backpressure, K boundaries, mid-stream reset and ignored inputs.
module tb_systolic_west_feeder;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int D  = 8;
  localparam int KW = $clog2(D+1);
  localparam int LW = R*W;
  localparam logic [LW-1:0] JUNK = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_data = '0;
  logic [LW-1:0] west;
  logic [R-1:0]  west_valid;
  logic          busy;
  logic          done;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [LW-1:0] beats [16];
  logic          hold_start = 1'b0;

  systolic_west_feeder #(.WIDTH(W), .ROWS(R), .DEPTH(D)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .k_len_i     (k_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .west_o      (west),
    .west_valid_o(west_valid),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_beats(input int base);
    for (int k = 0; k < 16; k++)
      for (int r = 0; r < R; r++)
        beats[k][r*W +: W] = 8'(base + 10*k + r);
  endtask

  task automatic start_tile(input int kreq);
    start    = 1'b1;
    k_len    = KW'(kreq);
    in_valid = 1'b0;
    @(negedge clk);
    start = hold_start;
  endtask

  // Offers beats under a valid mask (bit i = slot i); ends at STREAM cycle 0.
  task automatic feed(input int keff, input logic [15:0] mask);
    int   acc = 0;
    int   slot = 0;
    logic v;
    while (acc < keff && slot < 200) begin
      v        = (slot < 16) ? mask[slot] : 1'b1;
      in_valid = v;
      in_data  = v ? beats[acc] : JUNK;
      chk("ready_load", 64'(in_ready), 64'd1);
      if (v && in_ready) acc++;
      slot++;
      @(negedge clk);
    end
    if (acc < keff) chk("feed_timeout", 64'(acc), 64'(keff));
    chk("ready_drop", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = JUNK;
  endtask

  // Cycle c=0 is the first STREAM cycle; lane r beat k is due at c=k+r+1.
  task automatic observe(input int keff, input string tag);
    logic [LW-1:0] ew;
    logic [R-1:0]  ev;
    int            k;
    for (int c = 0; c <= keff + R; c++) begin
      if (c > 0) @(negedge clk);
      ew = '0;
      ev = '0;
      for (int r = 0; r < R; r++) begin
        k = c - r - 1;
        if (k >= 0 && k < keff) begin
          ew[r*W +: W] = beats[k][r*W +: W];
          ev[r]        = 1'b1;
        end
      end
      chk($sformatf("%s_vld_c%0d", tag, c), 64'(west_valid), 64'(ev));
      chk($sformatf("%s_west_c%0d", tag, c), 64'(west), 64'(ew));
      chk($sformatf("%s_done_c%0d", tag, c), 64'(done), 64'(c == keff + R));
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_vld", 64'(west_valid), 64'd0);
    chk("rst_west", 64'(west), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic tile
    fill_beats(0);
    start_tile(3);
    chk("basic_busy", 64'(busy), 64'd1);
    feed(3, 16'hFFFF);
    observe(3, "basic");

    // Backpressure: valid 1,0,0,1,1
    fill_beats(100);
    start_tile(3);
    feed(3, 16'hFFF9);
    observe(3, "bp");

    // K = 0
    start_tile(0);
    chk("k0_busy", 64'(busy), 64'd1);
    chk("k0_done_early", 64'(done), 64'd0);
    chk("k0_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("k0_done", 64'(done), 64'd1);
    chk("k0_busy_idle", 64'(busy), 64'd0);
    chk("k0_vld", 64'(west_valid), 64'd0);
    @(negedge clk);
    chk("k0_done_once", 64'(done), 64'd0);

    // K beyond DEPTH is clamped
    fill_beats(20);
    start_tile(D + 3);
    feed(D, 16'hFFFF);
    observe(D, "clamp");

    // Reset in the middle of STREAM (t=2)
    fill_beats(7);
    start_tile(3);
    feed(3, 16'hFFFF);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mrst_west", 64'(west), 64'd0);
    chk("mrst_vld", 64'(west_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_nodone_%0d", i), 64'(done), 64'd0);
      chk($sformatf("mrst_idle_%0d", i), 64'(busy), 64'd0);
    end
    beats[0] = {R{8'h80}};
    start_tile(1);
    feed(1, 16'hFFFF);
    observe(1, "neg");

    // start held high through a K=2 tile
    fill_beats(30);
    hold_start = 1'b1;
    start_tile(2);
    feed(2, 16'hFFFF);
    observe(2, "hold");
    @(negedge clk);
    chk("hold_restart_busy", 64'(busy), 64'd1);
    chk("hold_restart_ready", 64'(in_ready), 64'd1);
    hold_start = 1'b0;
    start      = 1'b0;
    fill_beats(60);
    feed(2, 16'hFFFF);
    observe(2, "hold2");
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_west_feeder.md
SYSTOLIC_WEST_FEEDER -- requirements
Module: systolic_west_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning signed element width in bits.
REQ-002 SHALL have parameter ROWS, default 4, meaning number of array rows fed, which is also the number of west lanes.
REQ-003 SHALL have parameter DEPTH, default 8, meaning maximum tile length K in beats.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rstn_i, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, meaning begin a tile (sampled in IDLE only).
REQ-007 SHALL have port k_len_i, input, $clog2(DEPTH+1), meaning tile length K (sampled with start_i).
REQ-008 SHALL have port in_valid_i, input, 1, meaning upstream beat valid.
REQ-009 SHALL have port in_ready_o, output, 1, meaning feeder accepts a beat.
REQ-010 SHALL have port in_data_i, input, ROWS*WIDTH, meaning one signed element per row; lane r is bits [r*WIDTH +: WIDTH].
REQ-011 SHALL have port west_o, output, ROWS*WIDTH, meaning skewed signed west operands to PE column 0, one lane per row.
REQ-012 SHALL have port west_valid_o, output, ROWS, meaning per-lane qualifier that west_o lane r carries tile data.
REQ-013 SHALL have port busy_o, output, 1, meaning state is not IDLE.
REQ-014 SHALL have port done_o, output, 1, meaning one-cycle pulse when the tile has fully drained.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, STREAM and DONE.
REQ-016 IDLE: in_ready_o=0; start_i=1 with 1<=K<=DEPTH SHALL latch K, clear wr_ptr and go to LOAD.
REQ-017 IDLE: start_i=1 with K=0 SHALL go to DONE directly, so done_o pulses without streaming.
REQ-018 IDLE: start_i=1 with K>DEPTH SHALL clamp K to DEPTH.
REQ-019 LOAD: in_ready_o=1; each beat with in_valid_i&in_ready_o SHALL be written to buf[wr_ptr], and wr_ptr SHALL increment.
REQ-020 LOAD: the accepted beat with wr_ptr==K-1 SHALL cause in_ready_o=0 on the next cycle and a transition to STREAM; no (K+1)th beat is accepted.
REQ-021 LOAD: in_valid_i=0 SHALL hold state indefinitely (no timeout).
REQ-022 STREAM: counter t SHALL run from 0 to K+ROWS-2, for K+ROWS-1 cycles in total; after the last cycle the FSM SHALL go to DONE.
REQ-023 STREAM: lane r SHALL present element buf[t-r][r] on west_o during registered output cycle t+1 when 0<=t-r<K, with west_valid_o[r]=1; otherwise lane r is 0 with west_valid_o[r]=0.
REQ-024 Latency: element k of lane r SHALL appear k+r+1 cycles after the first STREAM cycle, giving a diagonal skew of one cycle per row.
REQ-025 DONE: done_o=1 for exactly one cycle, then the FSM SHALL return to IDLE; busy_o=0 in that IDLE cycle.
REQ-026 start_i SHALL be ignored in LOAD, STREAM and DONE.
REQ-027 in_valid_i outside LOAD SHALL be ignored, and buffer contents SHALL be unchanged.
REQ-028 Data SHALL pass through bit-exact: no arithmetic, saturation or sign change.
REQ-029 Outside STREAM-driven cycles, west_o SHALL be 0 and west_valid_o SHALL be 0.

Reset
REQ-030 rstn_i=0 SHALL, asynchronously, set state=IDLE, in_ready_o=0, west_o=0, west_valid_o=0, busy_o=0, done_o=0, t=0, wr_ptr=0 and K=0.
REQ-031 Buffer contents SHALL not require reset.
REQ-032 Reset asserted mid-LOAD or mid-STREAM SHALL abort the tile with no done_o; a new start_i after release SHALL begin a clean tile.

Structure
REQ-033 Shared package systolic_pkg SHALL hold the feeder state enum (IDLE, LOAD, STREAM, DONE) and the default WIDTH/ROWS/DEPTH constants.
REQ-034 One sub-module skew_delay_line SHALL provide a parameterised-length register chain carrying data and valid; lane r instantiates length r, with lane 0 length 0 (pass-through).
REQ-035 Buffer reads SHALL be buf[t] for t<K and zero/invalid otherwise, feeding all lanes, with skew applied only by skew_delay_line.

Verification
REQ-036 Basic tile: ROWS=4, K=3, lane r of beat k = 10k+r; expected output:
- Lane 0 carries 0,10,20 on STREAM cycles 1-3.
- Lane 3 carries 3,13,23 on cycles 4-6.
- done_o pulses once, 7 cycles after entering STREAM.
REQ-037 Backpressure: in_valid_i toggled 1,0,0,1,1 with K=3 -> exactly 3 beats stored in order; in_ready_o drops the cycle after the 3rd accept; the 4th valid beat is ignored.
REQ-038 Edge lengths: cover both boundary values of K.
- K=0: done_o pulses with no west_valid_o activity.
- K=DEPTH+3 (clamped): DEPTH beats are accepted and the stream lasts DEPTH+ROWS-1 cycles.
REQ-039 Reset mid-STREAM at t=2: all outputs 0 immediately and no done_o; a following K=1 tile with value -128 on all lanes emits -128 bit-exact with the correct skew.
REQ-040 Ignored inputs: start_i held high throughout a K=2 tile -> a single tile, a single done_o, then a new tile starts from IDLE; in_valid_i during STREAM does not corrupt output data.
